// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and opcode constants used by the
// stall/flush sequencer and the hazard-detection logic.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/pipe_ctrl_wait_timer.sv
// Saturating data-memory wait counter with watchdog compare.
// A MAX_WAIT of 0 disables timeout_hit entirely.
module pipe_wait_timer #(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_inc,
  output logic o_timeout_hit
);

  logic [WAIT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= WAIT_W'(1);
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_timeout_hit = (MAX_WAIT != 0) && (r_cnt == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: combinational
// pipeline-register enables, data-memory wait FSM, watchdog, halt, stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned WAIT_W   = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_hz,
  input  logic             branch_hz,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_flush,
  output logic             ex_mem_we,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  state_e             r_state;
  state_e             w_next;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_stall;
  logic               w_freeze;
  logic               w_start;
  logic               w_inc;
  logic               w_set_timeout;
  logic               w_timeout_hit;

  pipe_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (w_start),
    .i_inc         (w_inc),
    .o_timeout_hit (w_timeout_hit)
  );

  // A completing MEM_WAIT cycle is evaluated like RUN with dmem_req ignored,
  // so the freeze condition is the only place the two states differ.
  assign w_freeze = ((r_state == RUN) && dmem_req && !dmem_ready) ||
                    ((r_state == MEM_WAIT) && !dmem_ready);

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_we     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_we    = 1'b1;
    mem_wb_flush = 1'b0;
    if (!rst_n) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_we     = 1'b0;
      id_ex_flush  = 1'b1;
      ex_mem_we    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (r_state == HALT) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
    end else if (w_freeze) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (load_use_hz || branch_hz) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_flush  = 1'b1;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
    end else if (!imem_ready) begin
      pc_we        = 1'b0;
      if_id_flush  = 1'b1;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_start       = 1'b0;
    w_inc         = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      RUN: begin
        if (halt_req) begin
          w_next = HALT;
        end else if (w_freeze) begin
          w_next  = MEM_WAIT;
          w_start = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          w_next = halt_req ? HALT : RUN;
        end else begin
          w_inc = 1'b1;
          if (w_timeout_hit) begin
            w_next        = HALT;
            w_set_timeout = 1'b1;
          end
        end
      end
      HALT:    w_next = HALT;
      default: w_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_timeout <= 1'b0;
      r_stall   <= '0;
    end else begin
      r_state <= w_next;
      if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
      if ((r_state != HALT) && !pc_we && (r_stall != '1)) begin
        r_stall <= r_stall + 1'b1;
      end
    end
  end

  assign halted       = (r_state == HALT);
  assign mem_timeout  = r_timeout;
  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: a watchdog instance (MAX_WAIT=4)
// and a narrow-counter instance (CNT_W=3) driven by the same stimulus.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n, load_use_hz, branch_hz, branch_taken;
  logic imem_ready, dmem_req, dmem_ready, halt_req;

  logic        pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush;
  logic        halted, mem_timeout;
  logic [31:0] stall_cycles;

  logic        s_pc_we, s_if_id_we, s_if_id_flush, s_id_ex_we, s_id_ex_flush, s_ex_mem_we, s_mem_wb_flush;
  logic        s_halted, s_mem_timeout;
  logic [2:0]  s_stall_cycles;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  // Expected control vectors: {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush}
  localparam logic [6:0] C_RST  = 7'b0010101;
  localparam logic [6:0] C_RUN  = 7'b1101010;
  localparam logic [6:0] C_FRZ  = 7'b0000001;
  localparam logic [6:0] C_HAZ  = 7'b0001110;
  localparam logic [6:0] C_BR   = 7'b1111010;
  localparam logic [6:0] C_MISS = 7'b0111010;
  localparam logic [6:0] C_HALT = 7'b0000000;

  // Input vectors: {rst_n, load_use_hz, branch_hz, branch_taken, imem_ready, dmem_req, dmem_ready, halt_req}
  localparam logic [7:0] I_RST  = 8'b0000_0000;
  localparam logic [7:0] I_IDLE = 8'b1000_1000;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .MAX_WAIT (4),
    .WAIT_W   (8),
    .CNT_W    (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_use_hz  (load_use_hz),
    .branch_hz    (branch_hz),
    .branch_taken (branch_taken),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .halt_req     (halt_req),
    .pc_we        (pc_we),
    .if_id_we     (if_id_we),
    .if_id_flush  (if_id_flush),
    .id_ex_we     (id_ex_we),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_we    (ex_mem_we),
    .mem_wb_flush (mem_wb_flush),
    .halted       (halted),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles)
  );

  pipe_ctrl #(
    .MAX_WAIT (255),
    .WAIT_W   (8),
    .CNT_W    (3)
  ) dut_s (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_use_hz  (load_use_hz),
    .branch_hz    (branch_hz),
    .branch_taken (branch_taken),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .halt_req     (halt_req),
    .pc_we        (s_pc_we),
    .if_id_we     (s_if_id_we),
    .if_id_flush  (s_if_id_flush),
    .id_ex_we     (s_id_ex_we),
    .id_ex_flush  (s_id_ex_flush),
    .ex_mem_we    (s_ex_mem_we),
    .mem_wb_flush (s_mem_wb_flush),
    .halted       (s_halted),
    .mem_timeout  (s_mem_timeout),
    .stall_cycles (s_stall_cycles)
  );

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty obs=%0h exp=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s obs=%0h exp=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // One clock cycle: drive at negedge, check combinational controls mid-cycle,
  // then check registered state just after the rising edge. es < 0 skips the
  // narrow-counter check.
  task automatic cyc(input string name, input logic [7:0] in, input logic [6:0] ectl,
                     input int unsigned estall, input logic eh, input logic eto, input int es);
    @(negedge clk);
    {rst_n, load_use_hz, branch_hz, branch_taken, imem_ready, dmem_req, dmem_ready, halt_req} = in;
    push({name, ".ctl"}, {25'd0, ectl});
    push({name, ".stall"}, estall);
    push({name, ".halted"}, {31'd0, eh});
    push({name, ".timeout"}, {31'd0, eto});
    if (es >= 0) push({name, ".stall_s"}, es);
    #1;
    chk({25'd0, pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush});
    @(posedge clk);
    #1;
    chk(stall_cycles);
    chk({31'd0, halted});
    chk({31'd0, mem_timeout});
    if (es >= 0) chk({29'd0, s_stall_cycles});
  endtask

  initial begin
    #100000;
    $display("FAIL bench_timeout obs=running exp=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    {rst_n, load_use_hz, branch_hz, branch_taken, imem_ready, dmem_req, dmem_ready, halt_req} = 8'b0111_1111;

    // Reset held with every other input high
    cyc("rst0", 8'b0111_1111, C_RST, 0, 1'b0, 1'b0, 0);
    cyc("rst1", 8'b0111_1111, C_RST, 0, 1'b0, 1'b0, 0);
    cyc("idle", I_IDLE,       C_RUN, 0, 1'b0, 1'b0, 0);

    // Load-use bubble
    cyc("ldu",  8'b1100_1000, C_HAZ, 1, 1'b0, 1'b0, 1);

    // Data wait with branch stall and redirect also pending; stall wins on ready
    cyc("rstA", I_RST,        C_RST, 0, 1'b0, 1'b0, 0);
    cyc("sim0", 8'b1011_1100, C_FRZ, 1, 1'b0, 1'b0, -1);
    cyc("sim1", 8'b1011_1100, C_FRZ, 2, 1'b0, 1'b0, -1);
    cyc("sim2", 8'b1011_1100, C_FRZ, 3, 1'b0, 1'b0, -1);
    cyc("simR", 8'b1011_1110, C_HAZ, 4, 1'b0, 1'b0, -1);
    cyc("sidl", I_IDLE,       C_RUN, 4, 1'b0, 1'b0, -1);

    // Redirect overrides a fetch miss
    cyc("brms", 8'b1001_0000, C_BR,  4, 1'b0, 1'b0, -1);

    // halt_req ignored while still waiting, honoured when the wait completes
    cyc("hw0",  8'b1000_1100, C_FRZ, 5, 1'b0, 1'b0, -1);
    cyc("hw1",  8'b1000_1101, C_FRZ, 6, 1'b0, 1'b0, -1);
    cyc("hwR",  8'b1000_1111, C_RUN, 6, 1'b1, 1'b0, -1);
    cyc("hwH",  8'b1111_0110, C_HALT, 6, 1'b1, 1'b0, -1);

    // Watchdog trips on the fourth wait cycle at MAX_WAIT=4
    cyc("rstB", I_RST,        C_RST, 0, 1'b0, 1'b0, 0);
    cyc("wd1",  8'b1000_1100, C_FRZ, 1, 1'b0, 1'b0, -1);
    cyc("wd2",  8'b1000_1100, C_FRZ, 2, 1'b0, 1'b0, -1);
    cyc("wd3",  8'b1000_1100, C_FRZ, 3, 1'b0, 1'b0, -1);
    cyc("wd4",  8'b1000_1100, C_FRZ, 4, 1'b0, 1'b0, -1);
    cyc("wd5",  8'b1000_1100, C_FRZ, 5, 1'b1, 1'b1, -1);
    cyc("wdH",  8'b1000_1110, C_HALT, 5, 1'b1, 1'b1, -1);
    cyc("wdH2", 8'b1100_0000, C_HALT, 5, 1'b1, 1'b1, -1);
    cyc("rstC", I_RST,        C_RST, 0, 1'b0, 1'b0, 0);

    // halt_req from RUN: current cycle advances, then HALT
    cyc("hrun", 8'b1000_1001, C_RUN, 0, 1'b1, 1'b0, 0);
    cyc("hrH",  8'b1010_1000, C_HALT, 0, 1'b1, 1'b0, 0);
    cyc("rstD", I_RST,        C_RST, 0, 1'b0, 1'b0, 0);

    // Fetch misses: 32-bit counter keeps counting, 3-bit counter saturates at 7
    for (int i = 1; i <= 10; i++) begin
      cyc($sformatf("miss%0d", i), 8'b1000_0000, C_MISS, i, 1'b0, 1'b0, (i > 7) ? 7 : i);
    end
    cyc("midl", I_IDLE,       C_RUN, 10, 1'b0, 1'b0, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Inputs: hazard requests (load-use, branch-compare operand stall), branch redirect from ID, and instruction/data memory handshakes.
- Outputs: per-pipeline-register write enables and flushes, plus PC write enable.
- Also owns the data-memory wait FSM, a wait watchdog, a halt state and a stall-cycle performance counter.

Parameters:
MAX_WAIT, 255, max consecutive MEM_WAIT cycles before timeout; 0 disables the watchdog
WAIT_W, 8, width of the wait counter; must satisfy MAX_WAIT < 2^WAIT_W
CNT_W, 32, width of the stall-cycle counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
load_use_hz  in  1  load-use hazard, ID consumer vs EX load
branch_hz  in  1  branch-compare stall (load in EX or MEM feeding branch in ID)
branch_taken  in  1  branch/jump resolved taken in ID this cycle
imem_ready  in  1  fetch data valid this cycle
dmem_req  in  1  EX/MEM holds a load/store
dmem_ready  in  1  data memory completes this cycle
halt_req  in  1  EBREAK/ECALL in MEM/WB
pc_we  out  1  PC update enable
if_id_we  out  1  IF/ID write enable
if_id_flush  out  1  IF/ID load bubble
id_ex_we  out  1  ID/EX write enable
id_ex_flush  out  1  ID/EX load bubble
ex_mem_we  out  1  EX/MEM write enable
mem_wb_flush  out  1  MEM/WB load bubble
halted  out  1  pipeline halted
mem_timeout  out  1  sticky watchdog flag
stall_cycles  out  CNT_W  saturating count of cycles with pc_we=0, excluding HALT and reset

Behaviour:
- Control outputs are combinational from state and inputs. State, counters and flags are registered.
- Reset: while rst_n=0, all *_we=0 and all *_flush=1. On the first edge with rst_n=0: state=RUN, wait_cnt=0, stall_cycles=0, halted=0, mem_timeout=0. Reset mid-MEM_WAIT or in HALT returns to RUN identically.
- States: RUN, MEM_WAIT, HALT.
- Default (RUN, no events): all *_we=1, all flushes=0.
- Priority in RUN, highest first:
  1. dmem_req && !dmem_ready: freeze everything. pc_we=if_id_we=id_ex_we=ex_mem_we=0, mem_wb_flush=1. Next state MEM_WAIT, wait_cnt<=1.
  2. load_use_hz || branch_hz: pc_we=0, if_id_we=0, id_ex_flush=1. EX/MEM and MEM/WB advance.
  3. branch_taken: pc_we=1 (external mux selects target), if_id_flush=1, rest advance. Overrides imem_ready=0, so the in-flight fetch is discarded.
  4. !imem_ready: pc_we=0, if_id_flush=1, rest advance.
- Lower-priority requests that lose are not latched. ID is frozen or re-presented, so hazard and branch inputs recur on a later cycle.
- MEM_WAIT:
  - Freeze outputs as in RUN rule 1 while dmem_ready=0; wait_cnt increments each such cycle.
  - dmem_ready=1: outputs are evaluated exactly as RUN, ignoring dmem_req, and next state is RUN.
  - Watchdog: MAX_WAIT!=0 and wait_cnt==MAX_WAIT with dmem_ready=0 sets mem_timeout=1 and next state HALT.
- halt_req (RUN, or MEM_WAIT completing): the current cycle completes normally, then next state is HALT. halt_req outranks the timeout check only when dmem_ready=1.
- HALT: all *_we=0, all flushes=0, halted=1. Exited only by reset.
- stall_cycles: increments when pc_we=0 in RUN or MEM_WAIT; holds at all-ones.
- wait_cnt saturates at all-ones and never wraps.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2);
  - opcode constants OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011, shared with hazard detection.
- One sub-module, pipe_wait_timer: saturating wait counter plus MAX_WAIT compare producing timeout_hit.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all inputs 1 → all *_we=0, flushes=1. After release with idle inputs → all *_we=1, stall_cycles=0, halted=0.
- Load-use: load_use_hz=1 for 1 cycle → pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1; stall_cycles=1.
- Simultaneous events: dmem_req=1, dmem_ready=0 for 3 cycles, with branch_hz=1 and branch_taken=1 → full freeze 3 cycles, state MEM_WAIT. On the ready cycle, branch_hz wins: id_ex_flush=1, if_id_flush=0. stall_cycles=4.
- Redirect during fetch miss: branch_taken=1 with imem_ready=0 → pc_we=1, if_id_flush=1.
- Watchdog: MAX_WAIT=4, dmem_ready held 0 → mem_timeout=1 after the 4th wait cycle, then HALT with halted=1. dmem_ready=1 afterwards leaves HALT unchanged. Reset clears it.
- Saturation: CNT_W=3, 10 consecutive imem_ready=0 cycles → stall_cycles=7 and holds.
